// File: rtl/riscv_pkg.sv
// Shared rv32 core types: fetch FIFO entry, fetch FSM states and the canonical NOP encoding.
package riscv_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush wins over push and pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int BUF_DEPTH = 2,
  localparam int AW        = $clog2(BUF_DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [BUF_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(BUF_DEPTH));

  // NOTE: the storage is reset too, so the presented head reads as all-zero coming out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rv32 instruction fetch: owns the PC, reads a 1-cycle BRAM and feeds decode over valid/ready.
// Optional FETCH_MISALIGN_TRAP_EN: a misaligned redirect presents an id_exc entry instead of aligning.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        id_exc
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t  state;
  logic [31:0]   pc;
  logic [31:0]   issued_pc;
  logic [31:0]   issue_addr;
  logic [31:0]   redir_pc;
  logic          inflight;
  logic          issue;
  logic          redir;
  logic          misaligned;
  logic          fifo_valid;
  logic          push;
  logic          pop;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic [CW:0]   occ_after;
  fetch_entry_t  head;
  fetch_entry_t  push_data;

  assign redir      = redirect_valid & resetn;
  assign redir_pc   = redirect_pc & 32'hFFFF_FFFC;
  assign fifo_valid = !empty && !redir;
  assign pop        = fifo_valid && id_ready;
  assign push       = inflight && !redir;
  assign push_data  = '{pc: issued_pc, instr: imem_rdata};
  // Entries committed once this cycle settles, counting the response still on the BRAM bus.
  assign occ_after  = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    issue      = 1'b0;
    issue_addr = pc;
    if (redir) begin
      issue      = !misaligned;
      issue_addr = redir_pc;
    end else if (state == BOOT) begin
      issue = 1'b1;
    end else if (state == RUN) begin
      issue = (occ_after < (CW+1)'(BUF_DEPTH));
    end
  end

  assign imem_en   = issue & resetn;
  assign imem_addr = issue_addr;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      issued_pc <= RESET_PC;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc        <= issue_addr + 32'd4;
        issued_pc <= issue_addr;
      end
      if (redir)               state <= misaligned ? TRAP : RUN;
      else if (state == BOOT)  state <= RUN;
    end
  end

  fetch_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redir),
    .head      (head),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

  // The issue rule must keep a push into a full FIFO always paired with a pop.
  assert property (@(posedge clk) disable iff (!resetn) !(full && push && !pop));

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        trap_pending;
  logic        trap_valid;
  logic [31:0] trap_pc;

  assign misaligned = (redirect_pc[1:0] != 2'b00);
  assign trap_valid = trap_pending && !redir;
  assign id_valid   = fifo_valid || trap_valid;
  assign id_exc     = trap_valid;
  assign id_pc      = trap_pending ? trap_pc : head.pc;
  assign id_instr   = trap_pending ? NOP : head.instr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      trap_pending <= 1'b0;
      trap_pc      <= '0;
    end else if (redir) begin
      trap_pending <= misaligned;
      trap_pc      <= redirect_pc;
    end else if (trap_valid && id_ready) begin
      trap_pending <= 1'b0;
    end
  end
`else
  assign misaligned = 1'b0;
  assign id_valid   = fifo_valid;
  assign id_pc      = head.pc;
  assign id_instr   = head.instr;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random ready/redirect traffic checked against a
// stream-level model (next expected fetch address, next expected pc presented to decode).
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        id_exc;
`endif

  int vectors;
  int miscompares;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .id_exc         (id_exc)
`endif
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // Instruction BRAM: one-cycle registered read.
  always @(posedge clk) if (imem_en) imem_rdata <= word_at(imem_addr);

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
  endtask

  task automatic expect_out(input string name, input logic [31:0] pc);
    @(negedge clk);
    vectors++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, pc, word_at(pc)}) begin
      miscompares++;
      $display("FAIL %s: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
               name, id_valid, id_pc, id_instr, pc, word_at(pc));
    end
  endtask

  task automatic expect_idle(input string name);
    @(negedge clk);
    vectors++;
    if (id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got id_valid=%b want 0", name, id_valid);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    repeat (2) next_cycle();
    vectors++;
    if ({imem_en, id_valid, imem_addr, id_pc, id_instr} !== {2'b00, RESET_PC, 64'h0}) begin
      miscompares++;
      $display("FAIL reset_values: got en=%b v=%b addr=%h pc=%h instr=%h want 0 0 %h 0 0",
               imem_en, id_valid, imem_addr, id_pc, id_instr, RESET_PC);
    end
    resetn = 1'b1;
    @(negedge clk);
    vectors++;
    if ({imem_en, imem_addr, id_valid} !== {1'b1, RESET_PC, 1'b0}) begin
      miscompares++;
      $display("FAIL boot_issue: got en=%b addr=%h v=%b want 1 %h 0",
               imem_en, imem_addr, id_valid, RESET_PC);
    end
    next_cycle();
    expect_idle("boot_cycle2");
    next_cycle();
    expect_out("boot_cycle3", RESET_PC);
    next_cycle();
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({id_valid, id_pc, id_instr, imem_en} !== {1'b1, 32'h4, word_at(32'h4), 1'b0}) begin
        miscompares++;
        $display("FAIL stall_hold: got v=%b pc=%h instr=%h en=%b want 1 00000004 %h 0",
                 id_valid, id_pc, id_instr, imem_en, word_at(32'h4));
      end
      next_cycle();
    end
    id_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      expect_out("stall_resume", 32'(4 * k));
      next_cycle();
    end
  endtask

  task automatic test_redirect_full();
    id_ready = 1'b0;
    repeat (2) next_cycle();
    drive(1'b1, 32'h40, 1'b1);
    @(negedge clk);
    vectors++;
    if ({id_valid, imem_en, imem_addr} !== {1'b0, 1'b1, 32'h40}) begin
      miscompares++;
      $display("FAIL redir_issue: got v=%b en=%b addr=%h want 0 1 00000040",
               id_valid, imem_en, imem_addr);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b1);
    expect_idle("redir_gap");
    next_cycle();
    expect_out("redir_first", 32'h40);
    next_cycle();
    expect_out("redir_second", 32'h44);
    next_cycle();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h80, 1'b1);
    expect_idle("b2b_first");
    next_cycle();
    drive(1'b1, 32'hC0, 1'b1);
    @(negedge clk);
    vectors++;
    if ({id_valid, imem_addr} !== {1'b0, 32'hC0}) begin
      miscompares++;
      $display("FAIL b2b_second: got v=%b addr=%h want 0 000000c0", id_valid, imem_addr);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b1);
    expect_idle("b2b_gap");
    next_cycle();
    expect_out("b2b_out0", 32'hC0);
    next_cycle();
    expect_out("b2b_out1", 32'hC4);
    next_cycle();
  endtask

  task automatic test_wrap();
    drive(1'b1, 32'hFFFF_FFF8, 1'b1);
    next_cycle();
    drive(1'b0, 32'h0, 1'b1);
    next_cycle();
    expect_out("wrap_fff8", 32'hFFFF_FFF8);
    next_cycle();
    expect_out("wrap_fffc", 32'hFFFF_FFFC);
    next_cycle();
    expect_out("wrap_0", 32'h0);
    next_cycle();
    expect_out("wrap_4", 32'h4);
    next_cycle();
  endtask

`ifdef FETCH_MISALIGN_TRAP_EN
  task automatic test_misalign();
    drive(1'b1, 32'h102, 1'b1);
    @(negedge clk);
    vectors++;
    if ({id_valid, imem_en} !== 2'b00) begin
      miscompares++;
      $display("FAIL trap_enter: got v=%b en=%b want 0 0", id_valid, imem_en);
    end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      drive(1'b0, 32'h0, (i == 1));
      @(negedge clk);
      vectors++;
      if ({id_valid, id_exc, id_pc, id_instr, imem_en} !== {2'b11, 32'h102, NOP, 1'b0}) begin
        miscompares++;
        $display("FAIL trap_entry: got v=%b exc=%b pc=%h instr=%h en=%b want 1 1 00000102 %h 0",
                 id_valid, id_exc, id_pc, id_instr, imem_en, NOP);
      end
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      vectors++;
      if ({id_valid, imem_en} !== 2'b00) begin
        miscompares++;
        $display("FAIL trap_idle: got v=%b en=%b want 0 0", id_valid, imem_en);
      end
    end
    next_cycle();
    drive(1'b1, 32'h200, 1'b1);
    @(negedge clk);
    vectors++;
    if ({imem_en, imem_addr, id_valid} !== {1'b1, 32'h200, 1'b0}) begin
      miscompares++;
      $display("FAIL trap_exit: got en=%b addr=%h v=%b want 1 00000200 0",
               imem_en, imem_addr, id_valid);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b1);
    next_cycle();
    expect_out("trap_resume", 32'h200);
    vectors++;
    if (id_exc !== 1'b0) begin
      miscompares++;
      $display("FAIL trap_resume_exc: got %b want 0", id_exc);
    end
    next_cycle();
  endtask
`else
  task automatic test_misalign();
    drive(1'b1, 32'h102, 1'b1);
    @(negedge clk);
    vectors++;
    if ({imem_en, imem_addr} !== {1'b1, 32'h100}) begin
      miscompares++;
      $display("FAIL align_issue: got en=%b addr=%h want 1 00000100", imem_en, imem_addr);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b1);
    next_cycle();
    expect_out("align_out0", 32'h100);
    next_cycle();
    expect_out("align_out1", 32'h104);
    next_cycle();
  endtask
`endif

  task automatic test_async_reset();
    #2;
    resetn = 1'b0;
    #1;
    vectors++;
    if ({imem_en, id_valid, imem_addr, id_pc, id_instr} !== {2'b00, RESET_PC, 64'h0}) begin
      miscompares++;
      $display("FAIL async_reset: got en=%b v=%b addr=%h pc=%h instr=%h want 0 0 %h 0 0",
               imem_en, id_valid, imem_addr, id_pc, id_instr, RESET_PC);
    end
    repeat (2) next_cycle();
    resetn = 1'b1;
    expect_idle("restart_cycle1");
    next_cycle();
    expect_idle("restart_cycle2");
    next_cycle();
    expect_out("restart_cycle3", RESET_PC);
    next_cycle();
  endtask

  task automatic test_random();
    logic [31:0] exp_out;
    logic [31:0] exp_fetch;
    logic [31:0] rpc;
    logic        rv;
    logic        rdy;
    int          quiet;
    exp_out   = '0;
    exp_fetch = '0;
    quiet     = 0;
    for (int i = 0; i < 600; i++) begin
      rv  = (i == 0) || ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rpc = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      rpc[1:0] = 2'b00;
`endif
      drive(rv, rpc, rdy);
      @(negedge clk);
      if (rv) begin
        exp_out   = rpc & 32'hFFFF_FFFC;
        exp_fetch = exp_out + 32'd4;
        quiet     = 1;
        vectors++;
        if ({id_valid, imem_en, imem_addr} !== {2'b01, exp_out}) begin
          miscompares++;
          $display("FAIL rand_redirect: got v=%b en=%b addr=%h want 0 1 %h",
                   id_valid, imem_en, imem_addr, exp_out);
        end
      end else begin
        if (imem_en) begin
          vectors++;
          if (imem_addr !== exp_fetch) begin
            miscompares++;
            $display("FAIL rand_fetch: got addr=%h want %h", imem_addr, exp_fetch);
          end
          exp_fetch += 32'd4;
        end
        vectors++;
        if (quiet > 0) begin
          quiet = 0;
          if (id_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_gap: got id_valid=%b want 0", id_valid);
          end
        end else if ({id_valid, id_pc, id_instr} !== {1'b1, exp_out, word_at(exp_out)}) begin
          miscompares++;
          $display("FAIL rand_out: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                   id_valid, id_pc, id_instr, exp_out, word_at(exp_out));
        end else if (rdy) begin
          exp_out += 32'd4;
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    test_reset();
    test_stall();
    test_redirect_full();
    test_back_to_back();
    test_wrap();
    test_misalign();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the rv32 core; first pipeline stage, directly upstream of decode. Owns the PC and issues word reads to the instruction BRAM, which has a fixed 1-cycle read latency. Buffers returned instructions in a small FIFO and presents them to decode over a valid/ready handshake. Accepts PC redirects from execute and flushes stale work on each one.

Parameters:
RESET_PC, 32'h0000_0000, address of the first fetch after reset
BUF_DEPTH, 2, instruction FIFO entries (power of two, ≥2)

Ports:
clk  in  1  core clock, rising edge
resetn  in  1  asynchronous active-low reset
imem_en  out  1  BRAM read enable
imem_addr  out  32  BRAM byte address, word aligned
imem_rdata  in  32  BRAM read data, valid the cycle after imem_en
redirect_valid  in  1  execute requests PC change (branch/jump taken)
redirect_pc  in  32  redirect target
id_valid  out  1  instruction available to decode
id_ready  in  1  decode accepts instruction
id_pc  out  32  PC of presented instruction
id_instr  out  32  presented instruction word

Behaviour:
- Clock clk; reset resetn, asynchronous, active-low. All state clears on assertion regardless of clock.
- Reset values: pc=RESET_PC, FIFO empty, inflight=0, state=BOOT, imem_en=0, imem_addr=RESET_PC, id_valid=0, id_pc=0, id_instr=0.
- FSM:
  - BOOT: first clocked cycle after resetn release. Issue at RESET_PC, go to RUN.
  - RUN: normal operation.
  - TRAP: only with the optional feature.
- Issue rule in RUN: imem_en=1 when occupancy + inflight - pop < BUF_DEPTH, where pop = id_valid & id_ready.
- On issue: imem_addr=pc, pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), inflight<=1. Otherwise inflight<=0.
- Response: when inflight=1 and not squashed, push {issued pc, imem_rdata} into the FIFO at the end of that cycle.
- Fetch latency: issue at cycle N, data in the FIFO at the edge ending N+1, id_valid high in N+2.
- Steady state with id_ready=1: one instruction per cycle.
- Output handshake:
  - id_valid = FIFO not empty; id_pc/id_instr = head entry.
  - Head is held stable while id_valid & !id_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
  - The issue rule guarantees the FIFO never overflows.
- Redirect (redirect_valid=1), highest priority:
  - Flush the FIFO in the same cycle; id_valid is forced 0 that cycle and any same-cycle pop is ignored.
  - Squash the response arriving this cycle (not pushed).
  - Issue at {redirect_pc[31:2],2'b00} this cycle; pc<=that+4.
  - id_valid rises 2 cycles later at the earliest.
  - Back-to-back redirects: the last one wins; each squashes the prior issue.
- Redirect in BOOT: redirect target overrides RESET_PC.
- Reset mid-operation: in-flight response discarded, FIFO empty, restart from BOOT.

Optional Feature:
Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Extra output id_exc (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 flushes as usual, issues nothing, and enters TRAP.
  - In TRAP: imem_en=0; presents one entry with id_valid=1, id_exc=1, id_pc=redirect_pc (unaligned), id_instr=32'h0000_0013 (NOP).
  - Stays in TRAP after that entry is accepted, until the next redirect, which is handled normally.
- Undefined: no id_exc port; the low two bits of redirect_pc are silently cleared.

Decomposition:
- riscv package gains:
  - NOP constant 32'h0000_0013.
  - fetch_entry_t packed struct {pc[31:0], instr[31:0]}.
  - fetch_state_t enum {BOOT, RUN, TRAP}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t.
  - Parameter BUF_DEPTH.
  - Ports push/pop/flush/empty/full/count.
  - Flush has priority over push and pop.

Test Plan:
- Reset release, id_ready=1, BRAM word k = 32'h1000_0000+k -> id_valid first high on cycle 3. Outputs (pc,instr) = (0,1000_0000), (4,1000_0001), ... one per cycle, no gaps.
- id_ready held 0 for 5 cycles from cycle 4 -> occupancy saturates at 2, imem_en drops to 0, head (4,1000_0001) stable. On release, sequence resumes with no loss or duplication.
- Redirect to 32'h40 while FIFO full and a read in flight -> id_valid 0 for the next 2 cycles. Next output pc=32'h40, then 32'h44.
- Redirect on two consecutive cycles to 32'h80 then 32'hC0 -> no 32'h80 instruction appears; first output pc=32'hC0.
- resetn pulsed low asynchronously mid-stream -> outputs at reset values immediately. Fetch restarts at RESET_PC.
- With FETCH_MISALIGN_TRAP_EN, redirect to 32'h102 -> single entry id_exc=1, id_pc=32'h102, id_instr=32'h13. imem_en stays 0 until redirect to 32'h200, which resumes normal fetch.
